// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the round-robin memory front end:
//   - arb_state_e     : arbiter FSM encodings (ST_IDLE / ST_XFER / ST_DRAIN)
//   - MEM_ARB_SLICE   : packed-slice index macro, device i of width w lives at
//                       [i*w +: w] inside a flattened per-device bus
//   - rr_pick()       : round-robin requester search
// No ports (package).
// -----------------------------------------------------------------------------
`ifndef MEM_ARB_PKG_SV
`define MEM_ARB_PKG_SV

`define MEM_ARB_SLICE(idx, w) ((idx) * (w)) +: (w)

package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

    // Widest request vector rr_pick() can search; callers zero-extend into it.
    localparam int MAX_DEV   = 32;
    localparam int MAX_DEV_W = 5;

    // Return the first requester found searching upward from ptr+1, wrapping
    // modulo num. If nothing requests, ptr is returned (callers qualify the
    // result with "any request" themselves).
    function automatic int rr_pick(
        input logic [MAX_DEV-1:0] req,
        input int                 ptr,
        input int                 num
    );
        int   pick;
        int   idx;
        logic found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 32'sd1; k <= MAX_DEV; k++) begin
            idx = (ptr + k) % num;
            if ((k <= num) && !found && req[idx[MAX_DEV_W-1:0]]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

`endif

// File: rtl/mem_sp_ram.sv
// -----------------------------------------------------------------------------
// mem_sp_ram
// Synchronous single-port RAM, 2**ADDR_W x DATA_W. Write on the clock edge
// when en & we; read data registered on the edge when en & !we, giving one
// cycle of read latency. The read register holds its value between reads and
// is the only state cleared by reset; array contents survive reset.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (read register only)
//   en, we          : access strobe, 1 = write / 0 = read
//   addr, di        : address and write data
//   rd_data         : registered read data
// -----------------------------------------------------------------------------
module mem_sp_ram #(
    parameter int    DATA_W    = 8,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] di,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_r;

    // Power-up image: all zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = '0;
        end
    end

    // Array write port.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_r[addr] <= di;
        end
    end

    // Registered read port; holds the last read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r <= '0;
        end else if (en && !we) begin
            rd_data_r <= mem_r[addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// NUM_DEV-port front end onto one single-port RAM. Requests are granted in
// round-robin order; each grant runs a single word or a BURST_LEN-beat burst,
// one RAM access per cycle at base+beat (address wraps).
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   dev_mem_en      : per-device request, held until the final ack
//   dev_burst_en    : 1 = burst, 0 = single word
//   dev_we          : 1 = write, 0 = read
//   dev_addr/dev_di : packed per-device base address / write data
//   dev_do_ack      : per-beat ack (write: same cycle, read: one cycle later)
//   mem_do          : shared read data, valid with a read ack
//   grant           : one-hot current owner, 0 when idle
//   busy            : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int    NUM_DEV   = 3,
    parameter int    ADDR_W    = 8,
    parameter int    DATA_W    = 8,
    parameter int    BURST_LEN = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_DEV-1:0]        dev_mem_en,
    input  logic [NUM_DEV-1:0]        dev_burst_en,
    input  logic [NUM_DEV-1:0]        dev_we,
    input  logic [NUM_DEV*ADDR_W-1:0] dev_addr,
    input  logic [NUM_DEV*DATA_W-1:0] dev_di,
    output logic [NUM_DEV-1:0]        dev_do_ack,
    output logic [DATA_W-1:0]         mem_do,
    output logic [NUM_DEV-1:0]        grant,
    output logic                      busy
);

    localparam int IDX_W  = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam logic [NUM_DEV-1:0] ONE_HOT0 = NUM_DEV'(32'd1);

    arb_state_e          state_r;
    arb_state_e          next_state_s;
    logic [NUM_DEV-1:0]  grant_r;
    logic [IDX_W-1:0]    gidx_r;
    logic                we_r;
    logic                burst_r;
    logic [ADDR_W-1:0]   base_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [IDX_W-1:0]    rr_ptr_r;
    logic [NUM_DEV-1:0]  rd_ack_r;

    logic [MAX_DEV-1:0]  req_ext_s;
    logic                any_req_s;
    logic [IDX_W-1:0]    pick_s;
    logic                en_g_s;
    logic                last_beat_s;
    logic                access_s;
    logic                leave_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [DATA_W-1:0]   ram_di_s;
    logic [NUM_DEV-1:0]  wr_ack_s;

    // Request search and per-beat access qualification.
    always_comb begin
        req_ext_s   = MAX_DEV'(dev_mem_en);
        any_req_s   = |dev_mem_en;
        pick_s      = IDX_W'(rr_pick(req_ext_s, int'(rr_ptr_r), NUM_DEV));
        en_g_s      = dev_mem_en[gidx_r];
        if (burst_r) begin
            last_beat_s = (beat_r == BEAT_W'(BURST_LEN - 1));
        end else begin
            last_beat_s = (beat_r == '0);
        end
        // Reset wins over an in-flight beat: no RAM write, no ack.
        access_s    = (state_r == ST_XFER) && en_g_s && !reset;
        // A low request in XFER is an abort: leave without accessing.
        leave_s     = (state_r == ST_XFER) && (!en_g_s || last_beat_s);
        ram_addr_s  = base_r + ADDR_W'(beat_r);
        ram_di_s    = dev_di[`MEM_ARB_SLICE(gidx_r, DATA_W)];
        if (access_s && we_r) begin
            wr_ack_s = grant_r;
        end else begin
            wr_ack_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_XFER;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (leave_s) begin
                    next_state_s = we_r ? ST_IDLE : ST_DRAIN;
                end else begin
                    next_state_s = ST_XFER;
                end
            end
            ST_DRAIN: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Transfer context: owner, direction, base, beat counter, rr pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r  <= '0;
            gidx_r   <= '0;
            we_r     <= 1'b0;
            burst_r  <= 1'b0;
            base_r   <= '0;
            beat_r   <= '0;
            rr_ptr_r <= IDX_W'(NUM_DEV - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r <= ONE_HOT0 << pick_s;
                        gidx_r  <= pick_s;
                        we_r    <= dev_we[pick_s];
                        burst_r <= dev_burst_en[pick_s];
                        base_r  <= dev_addr[`MEM_ARB_SLICE(pick_s, ADDR_W)];
                        beat_r  <= '0;
                    end
                end
                ST_XFER: begin
                    if (leave_s) begin
                        rr_ptr_r <= gidx_r;
                        // Reads keep the grant through DRAIN for the last ack.
                        if (we_r) begin
                            grant_r <= '0;
                        end
                    end else begin
                        beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                ST_DRAIN: grant_r <= '0;
                default:  grant_r <= '0;
            endcase
        end
    end

    // Read ack follows the read access by one cycle, in step with rd_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_r <= '0;
        end else if (access_s && !we_r) begin
            rd_ack_r <= grant_r;
        end else begin
            rd_ack_r <= '0;
        end
    end

    mem_sp_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .en      (access_s),
        .we      (we_r),
        .addr    (ram_addr_s),
        .di      (ram_di_s),
        .rd_data (mem_do)
    );

    assign dev_do_ack = rd_ack_r | wr_ack_s;
    assign grant      = grant_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Self-checking bench for mem_rr_arbiter: a default 3-device instance and a
// 5-device / 8-beat instance. Read expectations come from a bench-side memory
// model and are queued when a read is requested, then popped on each ack.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic [2:0]  en, burst, we;
    logic [23:0] addr, di;
    logic [2:0]  ack;
    logic [7:0]  mem_do;
    logic [2:0]  grant;
    logic        busy;

    logic [4:0]  en5, burst5, we5;
    logic [39:0] addr5, di5;
    logic [4:0]  ack5;
    logic [7:0]  mem_do5;
    logic [4:0]  grant5;
    logic        busy5;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  model [0:255];
    logic [7:0]  exp_q [$];
    logic [7:0]  wdata [0:7];

    always #5 clk = ~clk;

    mem_rr_arbiter u_dut (
        .clk(clk), .reset(reset), .dev_mem_en(en), .dev_burst_en(burst),
        .dev_we(we), .dev_addr(addr), .dev_di(di), .dev_do_ack(ack),
        .mem_do(mem_do), .grant(grant), .busy(busy)
    );

    mem_rr_arbiter #(.NUM_DEV(5), .ADDR_W(8), .DATA_W(8), .BURST_LEN(8)) u_dut5 (
        .clk(clk), .reset(reset), .dev_mem_en(en5), .dev_burst_en(burst5),
        .dev_we(we5), .dev_addr(addr5), .dev_di(di5), .dev_do_ack(ack5),
        .mem_do(mem_do5), .grant(grant5), .busy(busy5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One transaction on the 3-device instance. abort_after>0 drops the
    // request after that many acks. Returns ack count and the index of the
    // first ack, counted in negedges from the cycle the request was driven.
    task automatic run_xfer(input int dev, input logic we_i, input logic burst_i,
                            input logic [7:0] addr_i, input int abort_after,
                            output int n_acks, output int first_idx);
        int         beats;
        int         beat;
        logic       drop;
        logic       done;
        logic [7:0] a;
        beats = burst_i ? 4 : 1;
        beat = 0; drop = 1'b0; done = 1'b0; n_acks = 0; first_idx = -1;
        @(posedge clk); #1;
        en[dev] = 1'b1; we[dev] = we_i; burst[dev] = burst_i;
        addr[dev*8 +: 8] = addr_i; di[dev*8 +: 8] = wdata[0];
        if (!we_i) begin
            for (int k = 0; k < beats; k++) begin
                a = addr_i + 8'(k);
                exp_q.push_back(model[a]);
            end
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                chk("ack_owner", {29'd0, ack}, 32'd1 << dev);
                chk("grant_owner", {29'd0, grant}, 32'd1 << dev);
            end
            if (ack[dev]) begin
                if (first_idx < 0) first_idx = c;
                n_acks++;
                if (we_i) begin
                    a = addr_i + 8'(beat);
                    model[a] = wdata[beat];
                end else if (exp_q.size() > 0) begin
                    chk("rd_data", {24'd0, mem_do}, {24'd0, exp_q.pop_front()});
                end else begin
                    chk("rd_extra_ack", 32'(n_acks), 32'(beats));
                end
                beat++;
                if (n_acks == beats || n_acks == abort_after) drop = 1'b1;
            end
            if (drop && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (drop) en[dev] = 1'b0;
            else if (we_i) di[dev*8 +: 8] = wdata[beat];
        end
        chk("xfer_done", {31'd0, done}, 32'd1);
        en[dev] = 1'b0;
        exp_q.delete();
    endtask

    // 8-beat burst by device 4 on the 5-device instance, base 0x30,
    // write data / expected read data 0x50+beat.
    task automatic run5(input logic we_i, output int na);
        logic       done5;
        logic [7:0] e5;
        done5 = 1'b0; na = 0;
        @(posedge clk); #1;
        en5[4] = 1'b1; we5[4] = we_i; burst5[4] = 1'b1;
        addr5[32 +: 8] = 8'h30; di5[32 +: 8] = 8'h50;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (ack5 != 5'b00000) begin
                chk("t6_ack_owner", {27'd0, ack5}, 32'h10);
                chk("t6_grant", {27'd0, grant5}, 32'h10);
                if (!we_i) begin
                    e5 = 8'h50 + 8'(na);
                    chk("t6_rd_data", {24'd0, mem_do5}, {24'd0, e5});
                end
                na++;
            end
            if (na >= 8 && !busy5) begin
                done5 = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (na >= 8) en5[4] = 1'b0;
            else di5[32 +: 8] = 8'h50 + 8'(na);
        end
        chk("t6_done", {31'd0, done5}, 32'd1);
        en5[4] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         na, fi, nxt, last_dev;
        int         wins [0:2];
        logic       done;
        logic [7:0] a;

        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        reset = 1'b1;
        en = '0; burst = '0; we = '0; addr = '0; di = '0;
        en5 = '0; burst5 = '0; we5 = '0; addr5 = '0; di5 = {5{8'hEE}};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", {29'd0, ack}, 32'd0);
        chk("rst_grant", {29'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_do", {24'd0, mem_do}, 32'd0);
        chk("rst_busy5", {31'd0, busy5}, 32'd0);

        // 1: single write then single read on device 0
        wdata[0] = 8'hAB;
        run_xfer(0, 1'b1, 1'b0, 8'h10, 0, na, fi);
        chk("t1_wr_acks", 32'(na), 32'd1);
        chk("t1_wr_lat", 32'(fi), 32'd1);
        run_xfer(0, 1'b0, 1'b0, 8'h10, 0, na, fi);
        chk("t1_rd_acks", 32'(na), 32'd1);
        chk("t1_rd_lat", 32'(fi), 32'd2);

        // 2: burst write/read on device 1 across the address wrap
        wdata[0] = 8'h01; wdata[1] = 8'h02; wdata[2] = 8'h03; wdata[3] = 8'h04;
        run_xfer(1, 1'b1, 1'b1, 8'hFE, 0, na, fi);
        chk("t2_wr_acks", 32'(na), 32'd4);
        chk("t2_wr_lat", 32'(fi), 32'd1);
        run_xfer(1, 1'b0, 1'b1, 8'hFE, 0, na, fi);
        chk("t2_rd_acks", 32'(na), 32'd4);
        chk("t2_rd_lat", 32'(fi), 32'd2);
        chk("t2_model_wrap", {24'd0, model[8'h01]}, 32'h04);
        last_dev = 1;

        // 3: all three devices request single reads continuously
        addr[0 +: 8] = 8'h10; addr[8 +: 8] = 8'hFE; addr[16 +: 8] = 8'h01;
        we = '0; burst = '0;
        wins[0] = 0; wins[1] = 0; wins[2] = 0;
        nxt = (last_dev + 1) % 3; na = 0; done = 1'b0;
        @(posedge clk); #1;
        en = 3'b111;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ack != 3'b000) begin
                chk("t3_order", {29'd0, ack}, 32'd1 << nxt);
                a = addr[nxt*8 +: 8];
                chk("t3_data", {24'd0, mem_do}, {24'd0, model[a]});
                for (int i = 0; i < 3; i++) if (ack[i]) wins[i]++;
                nxt = (nxt + 1) % 3;
                na++;
            end
            if (na >= 6 && en == 3'b000 && !busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (na >= 6) en = 3'b000;
        end
        chk("t3_done", {31'd0, done}, 32'd1);
        for (int i = 0; i < 3; i++) chk("t3_fair", 32'(wins[i]), 32'd2);
        en = 3'b000;

        // 4: device 2 burst read, request dropped after the 2nd ack
        run_xfer(2, 1'b0, 1'b1, 8'hFE, 2, na, fi);
        chk("t4_acks_max", {31'd0, (na <= 3)}, 32'd1);
        chk("t4_acks_min", {31'd0, (na >= 2)}, 32'd1);
        run_xfer(0, 1'b0, 1'b0, 8'h10, 0, na, fi);
        chk("t4_next_acks", 32'(na), 32'd1);

        // 5: reset during a device 1 burst write, at beat 2
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        na = 0; done = 1'b0;
        @(posedge clk); #1;
        en[1] = 1'b1; we[1] = 1'b1; burst[1] = 1'b1; addr[8 +: 8] = 8'h80; di[8 +: 8] = wdata[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ack[1]) begin
                a = 8'h80 + 8'(na);
                model[a] = wdata[na];
                na++;
            end
            if (na == 2) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            di[8 +: 8] = wdata[na];
        end
        chk("t5_started", {31'd0, done}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        di[8 +: 8] = wdata[2];
        @(posedge clk); #1;
        reset = 1'b0;
        en[1] = 1'b0;
        @(negedge clk);
        chk("t5_ack", {29'd0, ack}, 32'd0);
        chk("t5_grant", {29'd0, grant}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        run_xfer(1, 1'b0, 1'b1, 8'h80, 0, na, fi);
        chk("t5_rd_acks", 32'(na), 32'd4);
        run_xfer(0, 1'b0, 1'b0, 8'h10, 0, na, fi);
        chk("t5_keep_acks", 32'(na), 32'd1);

        // 6: 5-device, 8-beat instance, device 4
        run5(1'b1, na);
        chk("t6_wr_acks", 32'(na), 32'd8);
        run5(1'b0, na);
        chk("t6_rd_acks", 32'(na), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
